// File: rtl/trail_grid_writer_pkg.sv
// Shared constants and helpers for the 64x48 trail grid; the pixel-side address
// converter uses the same cell numbering, with the menu image starting at MENU_BASE.
package trail_grid_writer_pkg;

  localparam int GRID_W     = 64;
  localparam int GRID_H     = 48;
  localparam int GRID_CELLS = GRID_W * GRID_H;
  localparam int MENU_BASE  = GRID_CELLS;
  localparam int ADDR_W     = 13;
  localparam int CELL_W     = 2;
  localparam int COORD_W    = 6;
  localparam int CNT_W      = 12;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 2'd0;
  localparam logic [CELL_W-1:0] CELL_P1    = 2'd1;
  localparam logic [CELL_W-1:0] CELL_P2    = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RD1,
    ST_RD2,
    ST_CHK,
    ST_WR1,
    ST_WR2,
    ST_FIN
  } state_t;

  // GRID_W is a power of two, so this reduces to the concatenation {y, x}
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/trail_cell_addr.sv
// Maps a bike head (x, y) to its trail RAM cell address and flags rows past the grid.
module trail_cell_addr
  import trail_grid_writer_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic               off_grid
);

  assign off_grid = (y >= COORD_W'(GRID_H));
  assign addr     = cell_addr(x, y);

endmodule

// File: rtl/trail_grid_writer.sv
// Game-side trail RAM writer: per tick reads both head cells, flags crashes and
// marks live heads as trail; sweeps the play area to empty after reset or on request.
module trail_grid_writer
  import trail_grid_writer_pkg::*;
(
  input  logic                clock,
  input  logic                resetn,
  input  logic                clear_req,
  input  logic                tick,
  input  logic [COORD_W-1:0]  p1_x,
  input  logic [COORD_W-1:0]  p1_y,
  input  logic [COORD_W-1:0]  p2_x,
  input  logic [COORD_W-1:0]  p2_y,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [CELL_W-1:0]   ram_wdata,
  output logic                ram_we,
  input  logic [CELL_W-1:0]   ram_rdata,
  output logic                busy,
  output logic                done,
  output logic                p1_crash,
  output logic                p2_crash,
  output logic                head_on
);

  state_t             state;
  logic [CNT_W-1:0]   clr_cnt;
  logic               pending_clear;
  logic [COORD_W-1:0] p1_x_q, p1_y_q, p2_x_q, p2_y_q;
  logic               occ1;

  // In IDLE the live inputs feed the converters so RD1 can drive addr1 straight
  // from the tick edge; afterwards only the latched heads are used.
  logic [COORD_W-1:0] sel_p1_x, sel_p1_y, sel_p2_x, sel_p2_y;
  logic [ADDR_W-1:0]  addr1, addr2;
  logic               off1, off2;

  assign sel_p1_x = (state == ST_IDLE) ? p1_x : p1_x_q;
  assign sel_p1_y = (state == ST_IDLE) ? p1_y : p1_y_q;
  assign sel_p2_x = (state == ST_IDLE) ? p2_x : p2_x_q;
  assign sel_p2_y = (state == ST_IDLE) ? p2_y : p2_y_q;

  trail_cell_addr u_addr1 (.x(sel_p1_x), .y(sel_p1_y), .addr(addr1), .off_grid(off1));
  trail_cell_addr u_addr2 (.x(sel_p2_x), .y(sel_p2_y), .addr(addr2), .off_grid(off2));

  logic occ2, same_cell, c1, c2;

  assign occ2      = (ram_rdata != CELL_EMPTY);
  assign same_cell = (sel_p1_x == sel_p2_x) && (sel_p1_y == sel_p2_y) && !off1;
  assign c1        = occ1 | off1 | same_cell;
  assign c2        = occ2 | off2 | same_cell;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (state == ST_IDLE && tick) begin
      p1_x_q <= p1_x;
      p1_y_q <= p1_y;
      p2_x_q <= p2_x;
      p2_y_q <= p2_y;
    end
    if (state == ST_RD2) begin
      occ1 <= (ram_rdata != CELL_EMPTY);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_CLEAR;
      clr_cnt       <= '0;
      pending_clear <= 1'b0;
      p1_crash      <= 1'b0;
      p2_crash      <= 1'b0;
      head_on       <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= CELL_EMPTY;
      done          <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      done   <= 1'b0;
      if (clear_req && state != ST_IDLE) begin
        pending_clear <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (pending_clear || clear_req) begin
            state         <= ST_CLEAR;
            clr_cnt       <= '0;
            pending_clear <= 1'b0;
          end else if (tick) begin
            state    <= ST_RD1;
            ram_addr <= off1 ? '0 : addr1;
          end
        end

        // clr_cnt is the next cell to write; reaching GRID_CELLS ends the sweep
        ST_CLEAR: begin
          if (clr_cnt == CNT_W'(GRID_CELLS)) begin
            p1_crash <= 1'b0;
            p2_crash <= 1'b0;
            head_on  <= 1'b0;
            done     <= 1'b1;
            state    <= ST_FIN;
          end else begin
            ram_we    <= 1'b1;
            ram_wdata <= CELL_EMPTY;
            ram_addr  <= ADDR_W'(clr_cnt);
            clr_cnt   <= clr_cnt + 1'b1;
          end
        end

        ST_RD1: begin
          ram_addr <= off2 ? '0 : addr2;
          state    <= ST_RD2;
        end

        ST_RD2: state <= ST_CHK;

        // A player already crashed on an earlier tick never writes again
        ST_CHK: begin
          p1_crash <= p1_crash | c1;
          p2_crash <= p2_crash | c2;
          if (same_cell) begin
            head_on <= 1'b1;
          end
          if (!(p1_crash | c1)) begin
            ram_we    <= 1'b1;
            ram_addr  <= addr1;
            ram_wdata <= CELL_P1;
          end
          state <= ST_WR1;
        end

        ST_WR1: begin
          if (!p2_crash) begin
            ram_we    <= 1'b1;
            ram_addr  <= addr2;
            ram_wdata <= CELL_P2;
          end
          state <= ST_WR2;
        end

        ST_WR2: begin
          done  <= 1'b1;
          state <= ST_FIN;
        end

        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trail_grid_writer.sv
// Bench for trail_grid_writer: sync RAM model, write monitor and a cell-level
// reference of the game rules, driven by directed steps plus random ticks.
module tb_trail_grid_writer;
  import trail_grid_writer_pkg::*;

  logic clock = 1'b0;
  logic resetn = 1'b1;
  logic clear_req = 1'b0;
  logic tick = 1'b0;
  logic [5:0] p1_x = '0, p1_y = '0, p2_x = '0, p2_y = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic [CELL_W-1:0] ram_wdata;
  logic ram_we;
  logic [CELL_W-1:0] ram_rdata;
  logic busy, done, p1_crash, p2_crash, head_on;

  trail_grid_writer dut (
    .clock(clock), .resetn(resetn), .clear_req(clear_req), .tick(tick),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .busy(busy), .done(done),
    .p1_crash(p1_crash), .p2_crash(p2_crash), .head_on(head_on)
  );

  always #5 clock = ~clock;

  logic [CELL_W-1:0] mem [0:4095];
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int wq[$];
  int bad_addr = 0;
  int we_idle = 0;
  always @(posedge clock) begin
    if (resetn) begin
      if (ram_we) begin
        wq.push_back(int'(ram_addr) * 4 + int'(ram_wdata));
        if (int'(ram_addr) >= MENU_BASE) bad_addr <= bad_addr + 1;
        if (!busy) we_idle <= we_idle + 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: grid contents, sticky flags, and the writes a tick should produce
  bit [1:0] ref_grid [0:GRID_CELLS-1];
  bit ex_p1, ex_p2, ex_ho;
  int exp_q[$];

  task automatic model_clear();
    for (int i = 0; i < GRID_CELLS; i++) ref_grid[i] = 2'd0;
    ex_p1 = 0; ex_p2 = 0; ex_ho = 0;
  endtask

  task automatic model_tick(input int x1, input int y1, input int x2, input int y2);
    bit off1, off2, hit1, hit2, same, cr1, cr2;
    int a1, a2;
    off1 = (y1 >= GRID_H);
    off2 = (y2 >= GRID_H);
    a1 = y1 * GRID_W + x1;
    a2 = y2 * GRID_W + x2;
    hit1 = !off1 && (ref_grid[a1] != 0);
    hit2 = !off2 && (ref_grid[a2] != 0);
    same = (x1 == x2) && (y1 == y2) && !off1;
    cr1 = hit1 || off1 || same;
    cr2 = hit2 || off2 || same;
    if (!cr1 && !ex_p1) begin exp_q.push_back(a1 * 4 + 1); ref_grid[a1] = 2'd1; end
    if (!cr2 && !ex_p2) begin exp_q.push_back(a2 * 4 + 2); ref_grid[a2] = 2'd2; end
    ex_p1 = ex_p1 | cr1;
    ex_p2 = ex_p2 | cr2;
    ex_ho = ex_ho | same;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_p1_crash"}, p1_crash, ex_p1);
    check({tag, "_p2_crash"}, p2_crash, ex_p2);
    check({tag, "_head_on"}, head_on, ex_ho);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, wq.size(), exp_q.size());
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
      check({tag, "_wr"}, wq[i], exp_q[i]);
    wq.delete();
    exp_q.delete();
  endtask

  // Called at posedge+1 with the DUT idle; coordinates are scrambled after the
  // tick cycle so the result must come from the values seen on the tick.
  task automatic run_tick(input int x1, input int y1, input int x2, input int y2, input string tag);
    int cyc;
    p1_x = 6'(x1); p1_y = 6'(y1); p2_x = 6'(x2); p2_y = 6'(y2);
    tick = 1'b1;
    @(posedge clock); #1;
    tick = 1'b0;
    p1_x = 6'($urandom); p1_y = 6'($urandom); p2_x = 6'($urandom); p2_y = 6'($urandom);
    check({tag, "_busy"}, busy, 1);
    cyc = 1;
    while (!done && cyc < 20) begin @(posedge clock); #1; cyc++; end
    check({tag, "_latency"}, cyc, 6);
    @(posedge clock); #1;
    check({tag, "_idle"}, {30'd0, busy, done}, 0);
    model_tick(x1, y1, x2, y2);
    compare_writes(tag);
    check_flags(tag);
  endtask

  // mode 0: wait only; 1: clear_req pulse; 2: pulse then tick mid-clear;
  // 3: clear_req and tick in the same idle cycle
  task automatic run_clear(input string tag, input int mode);
    int cyc, bad;
    if (mode != 0) begin
      clear_req = 1'b1;
      if (mode == 3) begin tick = 1'b1; p1_x = 6'd1; p1_y = 6'd1; p2_x = 6'd2; p2_y = 6'd2; end
      @(posedge clock); #1;
      clear_req = 1'b0;
      tick = 1'b0;
      if (mode == 2) begin
        repeat (3) @(posedge clock);
        #1; tick = 1'b1; p1_x = 6'd4; p1_y = 6'd4; p2_x = 6'd9; p2_y = 6'd9;
        @(posedge clock); #1; tick = 1'b0;
      end
    end
    cyc = 0;
    while (!done && cyc < 3300) begin @(posedge clock); #1; cyc++; end
    check({tag, "_done_seen"}, done, 1);
    @(posedge clock); #1;
    check({tag, "_nwr"}, wq.size(), GRID_CELLS);
    bad = 0;
    for (int i = 0; i < wq.size(); i++) if (wq[i] != i * 4) bad++;
    check({tag, "_order"}, bad, 0);
    wq.delete();
    model_clear();
    check_flags(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x1, y1, x2, y2, cyc;
    for (int i = 0; i < 4096; i++) mem[i] = (i < GRID_CELLS) ? 2'($urandom_range(1, 3)) : 2'd3;
    model_clear();

    #1 resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_addr, 0);
    check_flags("rst");
    resetn = 1'b1;

    run_clear("boot", 0);

    run_tick(5, 3, 60, 47, "t2");
    run_tick(5, 3, 20, 20, "t3");
    run_tick(6, 3, 21, 20, "t3b");

    run_clear("c4", 1);
    run_tick(10, 10, 10, 10, "t4");

    run_clear("c5", 1);
    run_tick(3, 4, 10, 48, "t5");

    run_clear("t6a", 2);
    run_clear("same", 3);

    // clear_req arrives while the tick sequence is in RD2
    p1_x = 6'd7; p1_y = 6'd7; p2_x = 6'd8; p2_y = 6'd8;
    tick = 1'b1;
    @(posedge clock); #1; tick = 1'b0;
    @(posedge clock); #1; clear_req = 1'b1;
    @(posedge clock); #1; clear_req = 1'b0;
    cyc = 3;
    while (!done && cyc < 20) begin @(posedge clock); #1; cyc++; end
    check("t6b_latency", cyc, 6);
    @(posedge clock); #1;
    model_tick(7, 7, 8, 8);
    compare_writes("t6b");
    run_clear("t6b_clr", 0);

    for (int n = 0; n < 20; n++) begin
      x1 = $urandom_range(0, 63); y1 = $urandom_range(0, 63);
      x2 = $urandom_range(0, 63); y2 = $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) begin x2 = x1; y2 = y1; end
      if (n % 4 == 0) begin x1 = $urandom_range(0, 3); y1 = 0; end
      run_tick(x1, y1, x2, y2, "rnd");
      if (n == 9) run_clear("rnd_clr", 1);
    end

    // Reset while the sweep is about 1000 cells in
    clear_req = 1'b1;
    @(posedge clock); #1; clear_req = 1'b0;
    cyc = 0;
    while (wq.size() < 1000 && cyc < 1200) begin @(posedge clock); #1; cyc++; end
    check("t7_reached", wq.size() >= 1000, 1);
    resetn = 1'b0;
    #1;
    check("t7_we", ram_we, 0);
    check("t7_busy", busy, 1);
    model_clear();
    check_flags("t7_rst");
    repeat (2) @(posedge clock);
    #1;
    check("t7_addr", ram_addr, 0);
    check("t7_done", done, 0);
    wq.delete();
    resetn = 1'b1;
    run_clear("t7", 0);

    check("no_menu_write", bad_addr, 0);
    check("no_we_idle", we_idle, 0);
    begin
      int menu_bad;
      menu_bad = 0;
      for (int i = GRID_CELLS; i < 4096; i++) if (mem[i] != 2'd3) menu_bad++;
      check("menu_intact", menu_bad, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
